// File: rtl/dmem_lsu_if.sv
// dmem_lsu_if
//   Bundles the three channels around the load/store unit:
//     req_*  request channel from the MEM stage (valid/ready)
//     rsp_*  response channel back to the MEM stage (valid/ready)
//     mem_*  raw port of the combinational byte-addressed data memory
//   Modports:
//     slave  - the LSU itself: accepts requests, produces responses and
//              drives the memory port
//     master - the environment around it: pipeline stage plus memory
interface dmem_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_fault;

  logic [31:0] mem_address;
  logic        mem_read_write;
  logic [31:0] mem_data_in;
  logic [1:0]  mem_access_size;
  logic [31:0] mem_data_out;

  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata,
    output req_ready,
    output rsp_valid, rsp_data, rsp_fault,
    input  rsp_ready,
    output mem_address, mem_read_write, mem_data_in, mem_access_size,
    input  mem_data_out
  );

  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata,
    input  req_ready,
    input  rsp_valid, rsp_data, rsp_fault,
    output rsp_ready,
    input  mem_address, mem_read_write, mem_data_in, mem_access_size,
    output mem_data_out
  );
endinterface

// File: rtl/dmem_lsu.sv
// dmem_lsu
//   Load/store initiator between the MEM pipeline stage and a combinational
//   byte-addressed data memory. One request is accepted per handshake,
//   classified (funct3 validity, address range, optional alignment), issued
//   to the memory for exactly one cycle, and answered on the response channel
//   with sign/zero-extended load data or a fault flag.
//
//   Ports:
//     clock  - single rising-edge clock
//     reset  - synchronous, active-high
//     bus    - dmem_lsu_if.slave (req_*, rsp_*, mem_* channels)
//
//   Parameters:
//     MEM_BASE  - byte address of memory byte 0
//     MEM_BYTES - memory size in bytes
//
//   Build option:
//     LSU_MISALIGN_TRAP_EN - when defined, misaligned halfword/word accesses
//                            fault instead of being issued to the memory.
//
//   All outputs are registered; the mem_* port sits at its idle values
//   (MEM_BASE, read, word, zero data) outside the single ACCESS cycle.
module dmem_lsu #(
  parameter logic [31:0] MEM_BASE  = 32'h01000000,
  parameter int unsigned MEM_BYTES = 1048576
) (
  input  logic      clock,
  input  logic      reset,
  dmem_lsu_if.slave bus
);

  // Address of the last valid byte, kept in 33 bits so the comparison with
  // addr + size - 1 never wraps.
  localparam logic [32:0] MEM_LAST = {1'b0, MEM_BASE} + 33'(MEM_BYTES) - 33'd1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_fault_q, rsp_fault_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] mem_address_q, mem_address_d;
  logic        mem_read_write_q, mem_read_write_d;
  logic [31:0] mem_data_in_q, mem_data_in_d;
  logic [1:0]  mem_access_size_q, mem_access_size_d;

  // ---------------------------------------------------------------------
  // Request classification (evaluated on the live request in IDLE)
  // ---------------------------------------------------------------------
  logic [1:0]  size_m1;
  logic [32:0] last_byte;
  logic        bad_funct3;
  logic        out_of_range;
  logic        misaligned;
  logic        req_fault;

  always_comb begin
    unique case (bus.req_funct3[1:0])
      2'd0:    size_m1 = 2'd0;
      2'd1:    size_m1 = 2'd1;
      default: size_m1 = 2'd3;
    endcase
  end

  assign last_byte    = {1'b0, bus.req_addr} + {31'd0, size_m1};
  assign out_of_range = (bus.req_addr < MEM_BASE) || (last_byte > MEM_LAST);

  // Loads reject 3, 6, 7; stores only know SB/SH/SW (0..2).
  assign bad_funct3 = bus.req_store ? (bus.req_funct3 > 3'd2)
                                    : ((bus.req_funct3[1:0] == 2'b11) ||
                                       (bus.req_funct3[2:1] == 2'b11));

`ifdef LSU_MISALIGN_TRAP_EN
  assign misaligned = ((bus.req_funct3[1:0] == 2'd1) && bus.req_addr[0]) ||
                      ((bus.req_funct3[1:0] == 2'd2) && (bus.req_addr[1:0] != 2'b00));
`else
  // The memory is byte-granular, so misaligned accesses are simply issued.
  assign misaligned = 1'b0;
`endif

  assign req_fault = bad_funct3 || out_of_range || misaligned;

  // ---------------------------------------------------------------------
  // Load data extension, applied to the memory read during ACCESS
  // ---------------------------------------------------------------------
  logic [31:0] load_ext;

  always_comb begin
    unique case (funct3_q)
      3'd0:    load_ext = {{24{bus.mem_data_out[7]}},  bus.mem_data_out[7:0]};
      3'd1:    load_ext = {{16{bus.mem_data_out[15]}}, bus.mem_data_out[15:0]};
      3'd4:    load_ext = {24'd0, bus.mem_data_out[7:0]};
      3'd5:    load_ext = {16'd0, bus.mem_data_out[15:0]};
      default: load_ext = bus.mem_data_out;
    endcase
  end

  // ---------------------------------------------------------------------
  // Next-state and registered-output logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d           = state_q;
    rsp_valid_d       = rsp_valid_q;
    rsp_data_d        = rsp_data_q;
    rsp_fault_d       = rsp_fault_q;
    funct3_d          = funct3_q;
    // The memory port returns to idle unless a non-faulting request is
    // being accepted this cycle; this is what limits a store to one cycle.
    mem_address_d     = MEM_BASE;
    mem_read_write_d  = 1'b0;
    mem_data_in_d     = 32'd0;
    mem_access_size_d = 2'd2;

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          funct3_d = bus.req_funct3;
          if (req_fault) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_fault_d = 1'b1;
            rsp_data_d  = 32'd0;
          end else begin
            state_d           = ACCESS;
            mem_address_d     = bus.req_addr;
            mem_read_write_d  = bus.req_store;
            mem_data_in_d     = bus.req_store ? bus.req_wdata : 32'd0;
            mem_access_size_d = bus.req_funct3[1:0];
          end
        end
      end

      ACCESS: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_fault_d = 1'b0;
        // Stores answer with zero data; mem_read_write_q marks this cycle's
        // access as a store.
        rsp_data_d  = mem_read_write_q ? 32'd0 : load_ext;
      end

      RESP: begin
        if (bus.rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          rsp_fault_d = 1'b0;
          rsp_data_d  = 32'd0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Ready is registered from the next state, so it is low through reset
    // and during the cycle a response is consumed.
    req_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q           <= IDLE;
      req_ready_q       <= 1'b0;
      rsp_valid_q       <= 1'b0;
      rsp_data_q        <= 32'd0;
      rsp_fault_q       <= 1'b0;
      funct3_q          <= 3'd2;
      mem_address_q     <= MEM_BASE;
      mem_read_write_q  <= 1'b0;
      mem_data_in_q     <= 32'd0;
      mem_access_size_q <= 2'd2;
    end else begin
      state_q           <= state_d;
      req_ready_q       <= req_ready_d;
      rsp_valid_q       <= rsp_valid_d;
      rsp_data_q        <= rsp_data_d;
      rsp_fault_q       <= rsp_fault_d;
      funct3_q          <= funct3_d;
      mem_address_q     <= mem_address_d;
      mem_read_write_q  <= mem_read_write_d;
      mem_data_in_q     <= mem_data_in_d;
      mem_access_size_q <= mem_access_size_d;
    end
  end

  assign bus.req_ready       = req_ready_q;
  assign bus.rsp_valid       = rsp_valid_q;
  assign bus.rsp_data        = rsp_data_q;
  assign bus.rsp_fault       = rsp_fault_q;
  assign bus.mem_address     = mem_address_q;
  assign bus.mem_read_write  = mem_read_write_q;
  assign bus.mem_data_in     = mem_data_in_q;
  assign bus.mem_access_size = mem_access_size_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu
//   Self-checking bench for dmem_lsu: a byte-array memory device answers the
//   mem_* port, a byte-level reference model predicts every response, and a
//   monitor pops expectations whenever a response handshake occurs.
//   Honors LSU_MISALIGN_TRAP_EN the same way the design does.
module tb_dmem_lsu;
  localparam logic [31:0] BASE  = 32'h01000000;
  localparam int unsigned BYTES = 1048576;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  dmem_lsu_if ifc();

  dmem_lsu #(.MEM_BASE(BASE), .MEM_BYTES(BYTES)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (ifc)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ------------------------------------------------------------------
  // Memory device: combinational read (refreshed mid-cycle), write at edge
  // ------------------------------------------------------------------
  logic [7:0] dev_mem [int unsigned];

  function automatic logic [7:0] dev_rd(input logic [31:0] a);
    return dev_mem.exists(a) ? dev_mem[a] : 8'h00;
  endfunction

  always @(posedge clock) begin
    if (ifc.mem_read_write) begin
      int n;
      n = (ifc.mem_access_size == 2'd0) ? 1 : (ifc.mem_access_size == 2'd1) ? 2 : 4;
      for (int i = 0; i < n; i++)
        dev_mem[ifc.mem_address + 32'(i)] = ifc.mem_data_in[8*i +: 8];
    end
  end

  always @(negedge clock) begin
    ifc.mem_data_out = {dev_rd(ifc.mem_address + 32'd3), dev_rd(ifc.mem_address + 32'd2),
                        dev_rd(ifc.mem_address + 32'd1), dev_rd(ifc.mem_address)};
  end

  // ------------------------------------------------------------------
  // Reference model
  // ------------------------------------------------------------------
  typedef struct {
    logic [31:0] data;
    logic        fault;
  } exp_t;

  exp_t exp_q[$];
  logic [7:0] ref_mem [int unsigned];

  function automatic int size_of(input logic [2:0] f3);
    if (f3[1:0] == 2'd0) return 1;
    if (f3[1:0] == 2'd1) return 2;
    return 4;
  endfunction

  function automatic exp_t ref_access(input logic st, input logic [2:0] f3,
                                      input logic [31:0] a, input logic [31:0] w);
    exp_t   e;
    int     n;
    logic   bad;
    longint lo;
    longint hi;
    logic [31:0] v;
    n   = size_of(f3);
    bad = st ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    lo  = longint'(a);
    hi  = lo + longint'(n) - 1;
    if (lo < longint'(BASE) || hi > longint'(BASE) + longint'(BYTES) - 1) bad = 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
    if (n > 1 && (lo % longint'(n)) != 0) bad = 1'b1;
`endif
    e.data  = 32'd0;
    e.fault = bad;
    if (bad) return e;
    if (st) begin
      for (int i = 0; i < n; i++) ref_mem[a + 32'(i)] = w[8*i +: 8];
      return e;
    end
    v = 32'd0;
    for (int i = 0; i < n; i++)
      v = v + ((ref_mem.exists(a + 32'(i)) ? 32'(ref_mem[a + 32'(i)]) : 32'd0) << (8*i));
    if (f3 == 3'd0 && v >= 32'h80)   v = v + 32'hFFFFFF00;
    if (f3 == 3'd1 && v >= 32'h8000) v = v + 32'hFFFF0000;
    e.data = v;
    return e;
  endfunction

  // ------------------------------------------------------------------
  // Response consumer
  // ------------------------------------------------------------------
  int rsp_mode = 2;  // 0 random, 1 hold low, 2 always ready

  initial begin
    ifc.rsp_ready = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      case (rsp_mode)
        0:       ifc.rsp_ready = 1'($urandom_range(0, 1));
        1:       ifc.rsp_ready = 1'b0;
        default: ifc.rsp_ready = 1'b1;
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Monitor: scoreboard pop, response hold, idle port, single-cycle write
  // ------------------------------------------------------------------
  logic        hold_prev = 1'b0;
  logic [31:0] hold_data = 32'd0;
  logic        hold_fault = 1'b0;
  int          wr_run = 0;

  always @(negedge clock) begin
    if (reset) begin
      hold_prev = 1'b0;
      wr_run    = 0;
    end else begin
      if (ifc.mem_read_write) begin
        wr_run++;
        check("write_one_cycle", 96'(wr_run), 96'd1);
      end else begin
        wr_run = 0;
      end
      if (ifc.req_ready || ifc.rsp_valid)
        check("mem_idle", {ifc.mem_address, ifc.mem_read_write, ifc.mem_access_size, ifc.mem_data_in},
              {BASE, 1'b0, 2'd2, 32'd0});
      if (hold_prev)
        check("rsp_hold", {ifc.rsp_valid, ifc.rsp_fault, ifc.rsp_data}, {1'b1, hold_fault, hold_data});
      if (ifc.rsp_valid && ifc.rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 96'd1, 96'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("rsp_data", ifc.rsp_data, e.data);
          check("rsp_fault", ifc.rsp_fault, e.fault);
        end
      end
      hold_prev  = ifc.rsp_valid && !ifc.rsp_ready;
      hold_data  = ifc.rsp_data;
      hold_fault = ifc.rsp_fault;
    end
  end

  // ------------------------------------------------------------------
  // Driver
  // ------------------------------------------------------------------
  task automatic wait_ready(output bit ok);
    int waited = 0;
    @(negedge clock);
    while (!ifc.req_ready && waited < 200) begin
      @(negedge clock);
      waited++;
    end
    ok = ifc.req_ready;
    if (!ok) check("req_ready_timeout", 96'd0, 96'd1);
  endtask

  task automatic drive(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
    ifc.req_store  = st;
    ifc.req_funct3 = f3;
    ifc.req_addr   = a;
    ifc.req_wdata  = w;
    ifc.req_valid  = 1'b1;
    @(posedge clock);
    #1;
    // Scramble the request after acceptance; the DUT must not look again.
    ifc.req_valid  = 1'b0;
    ifc.req_store  = 1'($urandom);
    ifc.req_funct3 = 3'($urandom);
    ifc.req_addr   = $urandom;
    ifc.req_wdata  = $urandom;
  endtask

  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] w, output exp_t e);
    bit ok;
    int lat;
    int writes;
    wait_ready(ok);
    e = ref_access(st, f3, a, w);
    if (!ok) return;
    exp_q.push_back(e);
    drive(st, f3, a, w);
    lat = 0;
    writes = 0;
    while (lat < 20) begin
      @(negedge clock);
      lat++;
      if (ifc.mem_read_write) writes++;
      if (lat == 1 && !e.fault)
        check("mem_port", {ifc.mem_address, ifc.mem_read_write, ifc.mem_access_size, ifc.mem_data_in},
              {a, st, f3[1:0], (st ? w : 32'd0)});
      if (ifc.rsp_valid) break;
    end
    check("rsp_latency", 96'(lat), (e.fault ? 96'd1 : 96'd2));
    check("store_write_cycles", 96'(writes), ((st && !e.fault) ? 96'd1 : 96'd0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // ------------------------------------------------------------------
  // Stimulus
  // ------------------------------------------------------------------
  initial begin
    exp_t e;
    bit   ok;
    ifc.req_valid  = 1'b0;
    ifc.req_store  = 1'b0;
    ifc.req_funct3 = 3'd0;
    ifc.req_addr   = 32'd0;
    ifc.req_wdata  = 32'd0;

    // Reset state
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_req_ready", ifc.req_ready, 1'b0);
    check("reset_rsp", {ifc.rsp_valid, ifc.rsp_fault, ifc.rsp_data}, 34'd0);
    check("reset_mem", {ifc.mem_address, ifc.mem_read_write, ifc.mem_access_size, ifc.mem_data_in},
          {BASE, 1'b0, 2'd2, 32'd0});
    reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check("reset_release_ready", ifc.req_ready, 1'b1);

    // Store / load word
    issue(1'b1, 3'd2, 32'h01000010, 32'hDEADBEEF, e);
    issue(1'b0, 3'd2, 32'h01000010, 32'h0, e);

    // Extension cases
    issue(1'b1, 3'd2, 32'h01000020, 32'h000080F0, e);
    issue(1'b0, 3'd0, 32'h01000020, 32'h0, e);
    issue(1'b0, 3'd4, 32'h01000020, 32'h0, e);
    issue(1'b0, 3'd1, 32'h01000020, 32'h0, e);
    issue(1'b0, 3'd5, 32'h01000020, 32'h0, e);

    // Byte store into the middle of a word
    issue(1'b1, 3'd0, 32'h01000021, 32'h12345677, e);
    issue(1'b0, 3'd2, 32'h01000020, 32'h0, e);

    // Range and funct3 boundaries
    issue(1'b0, 3'd2, 32'h00FFFFFC, 32'h0, e);
    issue(1'b0, 3'd2, BASE + BYTES - 2, 32'h0, e);
    issue(1'b1, 3'd2, BASE + BYTES - 2, 32'h11111111, e);
    issue(1'b1, 3'd0, BASE + BYTES - 1, 32'h000000A5, e);
    issue(1'b0, 3'd4, BASE + BYTES - 1, 32'h0, e);
    issue(1'b0, 3'd2, 32'hFFFFFFFF, 32'h0, e);
    issue(1'b0, 3'd3, 32'h01000020, 32'h0, e);
    issue(1'b0, 3'd6, 32'h01000020, 32'h0, e);
    issue(1'b1, 3'd5, 32'h01000020, 32'hFFFFFFFF, e);

    // Misaligned word (fault or byte-exact read depending on build)
    issue(1'b1, 3'd2, 32'h01000000, 32'h11223344, e);
    issue(1'b1, 3'd2, 32'h01000004, 32'h55667788, e);
    issue(1'b0, 3'd2, 32'h01000002, 32'h0, e);
    issue(1'b0, 3'd1, 32'h01000003, 32'h0, e);

    // Consumer stalls: response must hold, no new request accepted
    rsp_mode = 1;
    issue(1'b0, 3'd2, 32'h01000010, 32'h0, e);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("stall_hold", {ifc.rsp_valid, ifc.req_ready, ifc.rsp_fault, ifc.rsp_data},
            {1'b1, 1'b0, e.fault, e.data});
    end
    rsp_mode = 2;

    // Reset during the ACCESS cycle of a store: write lands, response dropped
    wait_ready(ok);
    if (ok) begin
      e = ref_access(1'b1, 3'd2, 32'h01000040, 32'hCAFEF00D);
      drive(1'b1, 3'd2, 32'h01000040, 32'hCAFEF00D);
      @(negedge clock);
      check("rst_access_write", ifc.mem_read_write, 1'b1);
      reset = 1'b1;
      @(posedge clock);
      @(negedge clock);
      check("rst_in_reset", {ifc.rsp_valid, ifc.req_ready, ifc.mem_read_write}, 3'b000);
      reset = 1'b0;
      @(posedge clock);
      @(negedge clock);
      check("rst_after", {ifc.rsp_valid, ifc.req_ready}, 2'b01);
    end
    issue(1'b0, 3'd2, 32'h01000040, 32'h0, e);

    // Randomized traffic with a randomly stalling consumer
    rsp_mode = 0;
    for (int t = 0; t < 300; t++) begin
      logic [31:0] a;
      int sel;
      sel = $urandom_range(0, 9);
      case (sel)
        0:       a = BASE - 32'($urandom_range(1, 4));
        1:       a = BASE + BYTES - 32'($urandom_range(1, 4));
        2:       a = $urandom;
        default: a = BASE + 32'($urandom_range(0, 31));
      endcase
      issue(1'($urandom), 3'($urandom_range(0, 7)), a, $urandom, e);
    end

    // Drain
    rsp_mode = 2;
    wait_ready(ok);
    check("scoreboard_empty", 96'(exp_q.size()), 96'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
